serial_adder_sub: RTL and testbench

//  Digit-serial adder/subtractor: the multi-cycle, parametrised successor of the 4-bit dataflow adder.

---
 rtl/serial_adder_sub.sv | 96 +++++++++
 tb/tb_serial_adder_sub.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_sub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB first, with start/done
// handshake and carry plus signed-overflow reporting.
module serial_adder_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C0,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             Overflow
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("serial_adder_sub: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh, b_sh, res, res_nx;
    logic             cy;
    logic [DIGIT:0]   dsum;
    logic [DIGIT-1:0] s;
    logic             c, cin_msb, accept, last;

    assign dsum    = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, cy};
    assign s       = dsum[DIGIT-1:0];
    assign c       = dsum[DIGIT];
    // Carry into the top bit of the digit recovered from its sum bit: s = a ^ b ^ cin.
    assign cin_msb = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ s[DIGIT-1];
    assign res_nx  = WIDTH'({s, res} >> DIGIT);

    assign accept = start && (state != RUN);
    assign last   = (state == RUN) && (cnt == LAST);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (cnt == LAST) state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            res      <= '0;
            cy       <= 1'b0;
            Sum      <= '0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
        end else if (accept) begin
            // Subtraction as A + ~B + ~C0.
            a_sh <= A;
            b_sh <= mode ? ~B : B;
            cy   <= mode ? ~C0 : C0;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> DIGIT;
            b_sh <= b_sh >> DIGIT;
            cy   <= c;
            res  <= res_nx;
            cnt  <= cnt + CW'(1);
            if (last) begin
                Sum      <= res_nx;
                Carry    <= c;
                Overflow <= c ^ cin_msb;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_sub.sv
// Directed checks of serial_adder_sub at 4x1 and 8x4, plus reference-model sweep at 8x4.
module tb_serial_adder_sub;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start4 = 0, c4 = 0, m4 = 0;
    logic [3:0] a4 = 0, b4 = 0;
    logic       busy4, done4, carry4, ovf4;
    logic [3:0] sum4;

    logic       start8 = 0, c8 = 0, m8 = 0;
    logic [7:0] a8 = 0, b8 = 0;
    logic       busy8, done8, carry8, ovf8;
    logic [7:0] sum8;

    serial_adder_sub #(.WIDTH(4), .DIGIT(1)) dut4 (
        .clock(clk), .reset(rst), .start(start4), .A(a4), .B(b4), .C0(c4), .mode(m4),
        .busy(busy4), .done(done4), .Sum(sum4), .Carry(carry4), .Overflow(ovf4));

    serial_adder_sub #(.WIDTH(8), .DIGIT(4)) dut8 (
        .clock(clk), .reset(rst), .start(start8), .A(a8), .B(b8), .C0(c8), .mode(m8),
        .busy(busy8), .done(done8), .Sum(sum8), .Carry(carry8), .Overflow(ovf8));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called #1 after an edge; returns #1 after the edge where busy drops.
    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic c, input logic m,
                          output int n);
        a4 = a; b4 = b; c4 = c; m4 = m; start4 = 1;
        @(posedge clk); #1;
        start4 = 0;
        n = 0;
        while (busy4 && n < 50) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic m,
                          output int n);
        a8 = a; b8 = b; c8 = c; m8 = m; start8 = 1;
        @(posedge clk); #1;
        start8 = 0;
        n = 0;
        while (busy8 && n < 50) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int n;
        logic seen;
        logic [8:0] full;
        logic [7:0] ra, rb, es;
        logic rc, rm, eo;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy4, 0);
        chk("rst_done", done4, 0);
        chk("rst_sum", sum4, 0);
        chk("rst_cy_ov", {carry4, ovf4}, 0);
        chk("rst_sum8", {busy8, done8, sum8, carry8, ovf8}, 0);
        rst = 0;
        @(posedge clk); #1;

        // T1
        issue4(4'b1000, 4'b0001, 0, 0, n);
        chk("t1_cycles", n, 4);
        chk("t1_done", done4, 1);
        chk("t1_sum", sum4, 4'b1001);
        chk("t1_cy_ov", {carry4, ovf4}, 2'b00);
        @(posedge clk); #1;
        chk("t1_done_pulse", done4, 0);
        chk("t1_hold", sum4, 4'b1001);

        // T2
        issue4(4'b1000, 4'b0001, 1, 0, n);
        chk("t2_sum", sum4, 4'b1010);
        chk("t2_cy_ov", {carry4, ovf4}, 2'b00);

        // T3
        issue4(4'b1000, 4'b1111, 0, 0, n);
        chk("t3_sum", sum4, 4'b0111);
        chk("t3_cy_ov", {carry4, ovf4}, 2'b11);

        // T4
        issue4(4'b0101, 4'b0111, 0, 1, n);
        chk("t4a_sum", sum4, 4'b1110);
        chk("t4a_cy_ov", {carry4, ovf4}, 2'b00);
        issue4(4'b0111, 4'b1000, 0, 1, n);
        chk("t4b_sum", sum4, 4'b1111);
        chk("t4b_cy_ov", {carry4, ovf4}, 2'b01);
        @(posedge clk); #1;

        // T5: start while busy ignored
        a4 = 4'b1000; b4 = 4'b0001; c4 = 0; m4 = 0; start4 = 1;
        @(posedge clk); #1;
        a4 = 4'b0011; b4 = 4'b0011; c4 = 1; m4 = 1;
        @(posedge clk); #1;
        start4 = 0;
        n = 1;
        while (busy4 && n < 50) begin
            n++;
            @(posedge clk); #1;
        end
        chk("t5_ign_cycles", n, 4);
        chk("t5_ign_sum", sum4, 4'b1001);
        chk("t5_ign_cy_ov", {carry4, ovf4}, 2'b00);

        // T5: start in the done cycle begins a new op (3 + 4 = 7)
        chk("t5_b2b_done", done4, 1);
        a4 = 4'b0011; b4 = 4'b0100; c4 = 0; m4 = 0; start4 = 1;
        @(posedge clk); #1;
        start4 = 0;
        chk("t5_b2b_state", {busy4, done4}, 2'b10);
        chk("t5_b2b_hold", sum4, 4'b1001);
        n = 0;
        while (busy4 && n < 50) begin
            n++;
            @(posedge clk); #1;
        end
        chk("t5_b2b_cycles", n, 4);
        chk("t5_b2b_sum", sum4, 4'b0111);
        @(posedge clk); #1;

        // T5: reset mid-RUN
        a4 = 4'b0110; b4 = 4'b0011; c4 = 0; m4 = 0; start4 = 1;
        @(posedge clk); #1;
        start4 = 0;
        @(posedge clk); #1;
        rst = 1;
        #1;
        chk("t5_rst_busy", busy4, 0);
        chk("t5_rst_done", done4, 0);
        chk("t5_rst_sum", sum4, 0);
        #2 rst = 0;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            seen |= done4 | busy4;
        end
        chk("t5_rst_nodone", seen, 0);

        // T6
        issue8(8'hFF, 8'h01, 0, 0, n);
        chk("t6_cycles", n, 2);
        chk("t6_done", done8, 1);
        chk("t6_sum", sum8, 8'h00);
        chk("t6_cy_ov", {carry8, ovf8}, 2'b10);

        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            rm = 1'($urandom);
            if (rm) begin
                full = {1'b0, ra} + {1'b0, ~rb} + {8'b0, ~rc};
                es = full[7:0];
                eo = (ra[7] != rb[7]) && (es[7] != ra[7]);
            end else begin
                full = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
                es = full[7:0];
                eo = (ra[7] == rb[7]) && (es[7] != ra[7]);
            end
            issue8(ra, rb, rc, rm, n);
            chk($sformatf("rnd%0d_cycles", i), n, 2);
            chk($sformatf("rnd%0d_sum", i), sum8, es);
            chk($sformatf("rnd%0d_cy_ov", i), {carry8, ovf8}, {full[8], eo});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
